// File: rtl/instr_encoder_loader.sv
// Packs R-type instruction fields into 32-bit words and streams them into
// instruction memory at consecutive word addresses through a small FIFO.
module instr_encoder_loader #(
    parameter int BITS   = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [6:0]        funct7,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BITS-1:0]   mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]    OCC_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]    OCC_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] WORD_INC = ADDR_W'(4);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_accepted;
    logic [ADDR_W-1:0] r_written;
    logic [BITS-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_occ;

    logic [BITS-1:0]   w_word;
    logic              w_full;
    logic              w_empty;
    logic              w_in_ready;
    logic              w_mem_we;
    logic              w_push;
    logic              w_pop;
    logic              w_last;

    assign w_word     = {funct7, rs2, rs1, funct3, rd, opcode};
    assign w_full     = (r_occ == OCC_FULL);
    assign w_empty    = (r_occ == '0);
    // Handshake terms depend only on registered state, never on in_valid/mem_ready.
    assign w_in_ready = (r_state == S_LOAD) && !w_full && (r_accepted < r_count);
    assign w_mem_we   = (r_state == S_LOAD) && !w_empty;
    assign w_push     = in_valid && w_in_ready;
    assign w_pop      = w_mem_we && mem_ready;
    assign w_last     = w_pop && (r_written == r_count - CNT_ONE);

    assign in_ready   = w_in_ready;
    assign mem_we     = w_mem_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = w_mem_we ? r_mem[r_rd_ptr] : '0;
    assign busy       = (r_state == S_LOAD);
    assign done       = (r_state == S_DONE);

    // Storage carries no reset: the occupancy counter alone defines validity.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_count    <= '0;
            r_accepted <= '0;
            r_written  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + PTR_ONE;
                r_accepted <= r_accepted + CNT_ONE;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + PTR_ONE;
                r_addr    <= r_addr + WORD_INC;
                r_written <= r_written + CNT_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_ONE;
                2'b01:   r_occ <= r_occ - OCC_ONE;
                default: r_occ <= r_occ;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr     <= {base_addr[ADDR_W-1:2], 2'b00};
                        r_count    <= count;
                        r_accepted <= '0;
                        r_written  <= '0;
                        r_state    <= (count != '0) ? S_LOAD : S_DONE;
                    end
                end
                S_LOAD: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a table of single-word sessions
// followed by hand-written multi-cycle sequences.
module tb_instr_encoder_loader;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [7:0]  count = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  opcode = '0;
    logic [4:0]  rd = '0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [6:0]  funct7 = '0;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic        busy;
    logic        done;

    instr_encoder_loader #(.BITS(32), .DEPTH(4), .ADDR_W(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .base_addr(base_addr), .count(count),
        .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .rd(rd), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .funct7(funct7), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [6:0] f7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] f3;
        logic [4:0] rd;
        logic [6:0] op;
    } tuple_t;

    typedef struct {
        tuple_t      t;
        logic [7:0]  base;
        logic [7:0]  exp_addr;
        logic [31:0] exp_word;
    } vec_t;

    tuple_t      tx_q[$];
    logic [7:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    int          ac_q[$];
    logic        acc = 1'b0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          done_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic tuple_t mk(input logic [6:0] op, input logic [4:0] rd_f,
                                  input logic [2:0] f3, input logic [4:0] r1,
                                  input logic [4:0] r2, input logic [6:0] f7);
        tuple_t t;
        t.op = op; t.rd = rd_f; t.f3 = f3; t.rs1 = r1; t.rs2 = r2; t.f7 = f7;
        return t;
    endfunction

    // Monitor: handshakes are sampled on the falling edge and complete on the next rising edge.
    always @(negedge CLK) begin
        cyc++;
        acc = in_valid && in_ready;
        if (acc) begin
            acc_cnt++;
            ac_q.push_back(cyc);
        end
        if (mem_we && mem_ready) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            wc_q.push_back(cyc);
            $display("cycle %0d write addr=0x%02h data=0x%08h", cyc, mem_addr, mem_wdata);
        end
        if (done) done_cnt++;
    end

    // Tuple driver: presents the queue head, advancing after each accepted handshake.
    always @(posedge CLK) begin
        #2;
        if (acc && tx_q.size() > 0) void'(tx_q.pop_front());
        in_valid = (tx_q.size() > 0);
        if (tx_q.size() > 0) begin
            opcode = tx_q[0].op; rd = tx_q[0].rd; funct3 = tx_q[0].f3;
            rs1 = tx_q[0].rs1; rs2 = tx_q[0].rs2; funct7 = tx_q[0].f7;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic start_session(input logic [7:0] b, input logic [7:0] c);
        start = 1'b1; base_addr = b; count = c;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string nm);
        int n;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        check({nm, "_done_seen"}, 32'(done_cnt > d0), 32'd1);
    endtask

    vec_t vec[5];
    int   w0, d0, a0, drift;
    logic [40:0] ref_snap;

    initial begin
        vec[0] = '{mk(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00), 8'h10, 8'h10, 32'h002081B3};
        vec[1] = '{mk(7'h33, 5'd5, 3'd0, 5'd6, 5'd7, 7'h20), 8'h13, 8'h10, 32'h407302B3};
        vec[2] = '{mk(7'h7F, 5'd31, 3'd7, 5'd31, 5'd31, 7'h7F), 8'hFF, 8'hFC, 32'hFFFFFFFF};
        vec[3] = '{mk(7'h00, 5'd0, 3'd5, 5'd0, 5'd0, 7'h00), 8'h40, 8'h40, 32'h00005000};
        vec[4] = '{mk(7'h13, 5'd10, 3'd0, 5'd10, 5'd31, 7'h00), 8'h80, 8'h80, 32'h01F50513};

        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        RST_N = 1'b1;
        tick();

        // Table: one-word sessions covering field placement and address alignment.
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            w0 = wa_q.size(); d0 = done_cnt;
            tx_q.push_back(vec[i].t);
            tick();
            start_session(vec[i].base, 8'd1);
            wait_done(d0, 20, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_nwrites", i), 32'(wa_q.size() - w0), 32'd1);
            check($sformatf("vec%0d_addr", i), 32'(wa_q[w0]), 32'(vec[i].exp_addr));
            check($sformatf("vec%0d_word", i), wd_q[w0], vec[i].exp_word);
            check($sformatf("vec%0d_busy_low", i), 32'(busy), 32'd0);
            tick();
            check($sformatf("vec%0d_done_pulses", i), 32'(done_cnt - d0), 32'd1);
        end

        // Streaming: three words on consecutive cycles, one cycle after first accept.
        w0 = wa_q.size(); d0 = done_cnt; a0 = ac_q.size();
        tx_q.push_back(mk(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00));
        tx_q.push_back(mk(7'h33, 5'd5, 3'd0, 5'd6, 5'd7, 7'h20));
        tx_q.push_back(mk(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00));
        tick();
        start_session(8'h10, 8'd3);
        wait_done(d0, 20, "stream");
        check("stream_nwrites", 32'(wa_q.size() - w0), 32'd3);
        check("stream_w0", wd_q[w0], 32'h002081B3);
        check("stream_w1", wd_q[w0+1], 32'h407302B3);
        check("stream_w2", wd_q[w0+2], 32'h002081B3);
        check("stream_a0", 32'(wa_q[w0]), 32'h10);
        check("stream_a1", 32'(wa_q[w0+1]), 32'h14);
        check("stream_a2", 32'(wa_q[w0+2]), 32'h18);
        check("stream_latency", 32'(wc_q[w0] - ac_q[a0]), 32'd1);
        check("stream_b2b_1", 32'(wc_q[w0+1] - wc_q[w0]), 32'd1);
        check("stream_b2b_2", 32'(wc_q[w0+2] - wc_q[w0+1]), 32'd1);
        tick();

        // Backpressure: FIFO fills to DEPTH and the write port holds steady.
        w0 = wa_q.size(); d0 = done_cnt; a0 = acc_cnt;
        mem_ready = 1'b0;
        for (int i = 1; i <= 6; i++) tx_q.push_back(mk(7'h33, 5'(i), 3'd0, 5'd1, 5'd2, 7'h00));
        tick();
        start_session(8'h20, 8'd6);
        repeat (3) tick();
        ref_snap = {mem_we, mem_addr, mem_wdata};
        drift = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if ({mem_we, mem_addr, mem_wdata} !== ref_snap) drift++;
        end
        check("bp_accepts", 32'(acc_cnt - a0), 32'd4);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_mem_we", 32'(mem_we), 32'd1);
        check("bp_head_addr", 32'(mem_addr), 32'h20);
        check("bp_head_word", mem_wdata, 32'h002080B3);
        check("bp_stable", 32'(drift), 32'd0);
        mem_ready = 1'b1;
        wait_done(d0, 40, "bp");
        check("bp_nwrites", 32'(wa_q.size() - w0), 32'd6);
        check("bp_w3", wd_q[w0+2], 32'h00208133 + 32'h80);
        check("bp_w6", wd_q[w0+5], 32'h00208333);
        check("bp_a6", 32'(wa_q[w0+5]), 32'h34);
        for (int i = 0; i < 6; i++) begin
            if (wa_q[w0+i] !== 8'(8'h20 + 4*i)) check($sformatf("bp_addr%0d", i), 32'(wa_q[w0+i]), 32'(8'h20 + 4*i));
        end
        tick();

        // Empty session: no writes, done in the cycle right after start.
        w0 = wa_q.size(); d0 = done_cnt;
        start_session(8'h10, 8'd0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        check("zero_mem_we", 32'(mem_we), 32'd0);
        tick();
        check("zero_done_low", 32'(done), 32'd0);
        repeat (3) tick();
        check("zero_nwrites", 32'(wa_q.size() - w0), 32'd0);

        // Address wrap at the top of the byte-address space.
        w0 = wa_q.size(); d0 = done_cnt;
        tx_q.push_back(mk(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00));
        tx_q.push_back(mk(7'h33, 5'd5, 3'd0, 5'd6, 5'd7, 7'h20));
        tick();
        start_session(8'hFC, 8'd2);
        wait_done(d0, 20, "wrap");
        check("wrap_nwrites", 32'(wa_q.size() - w0), 32'd2);
        check("wrap_a0", 32'(wa_q[w0]), 32'hFC);
        check("wrap_a1", 32'(wa_q[w0+1]), 32'h00);
        tick();

        // Over-supply with a stray start pulse during LOAD.
        w0 = wa_q.size(); d0 = done_cnt; a0 = acc_cnt;
        for (int i = 0; i < 5; i++) tx_q.push_back(mk(7'h33, 5'(i + 8), 3'd0, 5'd1, 5'd2, 7'h00));
        tick();
        start_session(8'h30, 8'd2);
        start_session(8'h80, 8'd5);
        wait_done(d0, 20, "over");
        tx_q.delete();
        repeat (4) tick();
        check("over_accepts", 32'(acc_cnt - a0), 32'd2);
        check("over_nwrites", 32'(wa_q.size() - w0), 32'd2);
        check("over_a0", 32'(wa_q[w0]), 32'h30);
        check("over_a1", 32'(wa_q[w0+1]), 32'h34);
        check("over_idle", 32'(busy), 32'd0);

        // Reset in the middle of a four-word session.
        w0 = wa_q.size();
        for (int i = 0; i < 4; i++) tx_q.push_back(mk(7'h33, 5'(i + 1), 3'd0, 5'd1, 5'd2, 7'h00));
        tick();
        start_session(8'h50, 8'd4);
        for (int n = 0; n < 20 && wa_q.size() - w0 < 2; n++) tick();
        check("rstmid_two_writes", 32'(wa_q.size() - w0), 32'd2);
        RST_N = 1'b0;
        tx_q.delete();
        #1;
        check("rstmid_in_ready", 32'(in_ready), 32'd0);
        check("rstmid_mem_we", 32'(mem_we), 32'd0);
        check("rstmid_mem_addr", 32'(mem_addr), 32'd0);
        check("rstmid_mem_wdata", mem_wdata, 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        repeat (2) tick();
        RST_N = 1'b1;
        repeat (2) tick();
        check("rstmid_idle", 32'(busy), 32'd0);
        check("rstmid_fifo_empty", 32'(mem_we), 32'd0);
        check("rstmid_no_more", 32'(wa_q.size() - w0), 32'd2);
        w0 = wa_q.size(); d0 = done_cnt;
        tx_q.push_back(mk(7'h33, 5'd5, 3'd0, 5'd6, 5'd7, 7'h20));
        tick();
        start_session(8'h40, 8'd1);
        wait_done(d0, 20, "rstmid_new");
        check("rstmid_new_n", 32'(wa_q.size() - w0), 32'd1);
        check("rstmid_new_addr", 32'(wa_q[w0]), 32'h40);
        check("rstmid_new_word", wd_q[w0], 32'h407302B3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the ID-stage field decoder: packs R-type-layout instruction fields (opcode, rd, funct3, rs1, rs2, funct7) into 32-bit instruction words.
- Streams the words into instruction memory at consecutive word addresses.
- Used at boot or by the test harness to load a program into IMEM before the core is released.
- Input side is a valid/ready field stream buffered by a small FIFO; output side is a write port with a ready handshake.

Parameters:
BITS, 32, instruction word width (fixed field layout requires 32)
DEPTH, 4, FIFO entries (power of two, >=2)
ADDR_W, 8, IMEM byte-address width

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
start  input  1  begin a load session (sampled in IDLE only)
base_addr  input  ADDR_W  first byte address, word aligned (bits[1:0] ignored, forced 0)
count  input  ADDR_W  number of instructions in session
in_valid  input  1  field tuple valid
in_ready  output  1  tuple accepted when in_valid & in_ready
opcode  input  7  field, placed in bits[6:0]
rd  input  5  field, placed in bits[11:7]
funct3  input  3  field, placed in bits[14:12]
rs1  input  5  field, placed in bits[19:15]
rs2  input  5  field, placed in bits[24:20]
funct7  input  7  field, placed in bits[31:25]
mem_we  output  1  write request
mem_addr  output  ADDR_W  write byte address
mem_wdata  output  BITS  encoded instruction
mem_ready  input  1  write completes when mem_we & mem_ready
busy  output  1  high in LOAD
done  output  1  one-cycle pulse at session end

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE, FIFO empty, counters 0.
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0.
  - Reset mid-session discards FIFO contents and partial progress; no further writes are issued.
- Encoding is combinational at push: word = {funct7, rs2, rs1, funct3, rd, opcode}; the FIFO stores encoded words.
- FSM states IDLE, LOAD, DONE:
  - IDLE:
    - start=1 latches base_addr & ~3 into the address register and count into remaining counters.
    - count!=0 -> LOAD. count==0 -> DONE; no writes are issued.
  - LOAD:
    - busy=1.
    - in_ready = !fifo_full & (accepted < count); it depends only on registered state.
    - Tuples beyond count are not accepted.
  - LOAD -> DONE when the count-th write completes.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored outside IDLE.
- Output port:
  - mem_we = FIFO non-empty while in LOAD.
  - mem_wdata = FIFO head; mem_addr = address register.
  - mem_we, mem_addr and mem_wdata hold stable until mem_ready.
  - On completion: pop FIFO, address += 4 (modulo 2^ADDR_W, wraps silently), written count += 1.
- Latency: a tuple accepted in cycle N appears on mem_we/mem_wdata no earlier than cycle N+1 (registered FIFO).
  - Back-to-back throughput is 1 word/cycle with mem_ready held high.
- Simultaneous push and pop:
  - Allowed when the FIFO is neither full nor empty; occupancy is unchanged.
  - When full, in_ready is already 0, so no push occurs that cycle even if a pop happens.
  - When empty, no pop occurs (mem_we=0).
- The last write and the DONE transition occur on the same edge; mem_we=0 in DONE.

Test Plan:
- Single encode: start, base_addr=0x10, count=1; tuple opcode=0x33, rd=3, funct3=0, rs1=1, rs2=2, funct7=0x00 -> one write, mem_addr=0x10, mem_wdata=0x002081B3, done pulses 1 cycle, busy falls.
- Streaming: count=3, tuples add x3,x1,x2; sub x5,x6,x7 (funct7=0x20); repeat add; mem_ready=1 -> writes 0x002081B3@0x10, 0x407302B3@0x14, 0x002081B3@0x18 on consecutive cycles.
- Backpressure: mem_ready=0 for 10 cycles, DEPTH=4, count=6 -> in_ready drops after 4 accepts; mem_we/mem_addr/mem_wdata stable; after release all 6 written in order, no loss or duplication.
- Boundary: count=0 -> no mem_we, done one cycle after start. base_addr=0xFC, count=2 -> addresses 0xFC then 0x00 (wrap). base_addr=0x13 -> first address 0x10.
- Over-supply and ignored start: count=2, in_valid held high for 5 cycles -> exactly 2 accepted; start pulsed during LOAD has no effect.
- Reset mid-op: RST_N low after 2 of 4 writes -> all outputs 0 immediately; after release, state IDLE with FIFO empty; new session starting at 0x40 writes from 0x40.
